// File: rtl/bus_arb_regfile.sv
// bus_arb_regfile: round-robin arbiter in front of a small shared register file.
// Each accepted request is served with a fixed number of wait states and is
// answered with a registered one-cycle response strobe on the granted channel.
module bus_arb_regfile #(
   parameter int NUM_CH      = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_CH-1:0]                     req_valid,
   output logic [NUM_CH-1:0]                     req_ready,
   input  logic [NUM_CH-1:0]                     req_write,
   input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     req_wdata,
   output logic [NUM_CH-1:0]                     rsp_valid,
   output logic [DATA_WIDTH-1:0]                 rsp_rdata,
   output logic                                  rsp_err,
   output logic                                  busy,
   output logic [31:0]                           txn_count
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   // counter only ever holds WAIT_CYCLES-1 down to 0
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0]    CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
   // one extra bit so DEPTH == 2^ADDR_WIDTH still compares correctly
   localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                  state_q, state_d;
   logic [CH_W-1:0]         last_q;
   logic                    write_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [NUM_CH-1:0]       rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic                    rsp_err_q;
   logic [31:0]             txn_q;

   logic                    found;
   logic [CH_W-1:0]         grant;
   int                      rr_idx;
   logic                    accept;
   logic                    fire;
   logic                    op_write;
   logic [ADDR_WIDTH-1:0]   op_addr;
   logic [DATA_WIDTH-1:0]   op_wdata;
   logic [CH_W-1:0]         op_ch;
   logic [IDX_W-1:0]        op_idx;
   logic                    in_range;

   // round-robin search starting one past the last granted channel
   always_comb begin
      found  = 1'b0;
      grant  = last_q;
      rr_idx = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
         rr_idx = int'(last_q) + i;
         if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
         if (!found && req_valid[CH_W'(rr_idx)]) begin
            found = 1'b1;
            grant = CH_W'(rr_idx);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (found) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
         S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: accept strobe is combinational, only offered from IDLE
   always_comb begin
      req_ready = '0;
      accept    = (state_q == S_IDLE) && found;
      if (accept) req_ready[grant] = 1'b1;
      busy      = (state_q != S_IDLE);
   end

   // operation seen at the RESP-entry edge: live request when wait is zero,
   // otherwise the captured one
   always_comb begin
      op_write = accept ? req_write[grant] : write_q;
      op_addr  = accept ? req_addr[grant]  : addr_q;
      op_wdata = accept ? req_wdata[grant] : wdata_q;
      op_ch    = accept ? grant            : last_q;
      op_idx   = op_addr[IDX_W-1:0];
      in_range = ({1'b0, op_addr} < DEPTH_L);
      fire     = (state_d == S_RESP);
   end

   // capture the accepted request and run the wait-state counter
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q  <= CH_W'(NUM_CH - 1);
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         last_q  <= grant;
         write_q <= req_write[grant];
         addr_q  <= req_addr[grant];
         wdata_q <= req_wdata[grant];
         cnt_q   <= CNT_LOAD;
      end else if (state_q == S_WAIT && cnt_q != '0) begin
         cnt_q   <= cnt_q - 1'b1;
      end
   end

   // storage: written on RESP entry for in-range writes only
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (fire && op_write && in_range) begin
         mem_q[op_idx] <= op_wdata;
      end
   end

   // registered response, visible during the RESP cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         txn_q       <= '0;
      end else begin
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         if (fire) begin
            rsp_valid_q[op_ch] <= 1'b1;
            rsp_err_q          <= !in_range;
            rsp_rdata_q        <= (!op_write && in_range) ? mem_q[op_idx] : '0;
            txn_q              <= txn_q + 32'd1;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign txn_count = txn_q;

endmodule
